// File: rtl/lcd_refresh_spi_if.sv
// Signal bundle between lcd_refresh_spi, its host, the frame-buffer RAM read port and the LCD SPI pins.
// The optional continuous-refresh macro LCD_REFRESH_CONT_EN is consumed in lcd_refresh_spi.sv.
interface lcd_refresh_spi_if;
  logic       start;
  logic       busy;
  logic       frame_done;
  logic [9:0] ram_addr_rd;
  logic       ram_rd;
  logic [7:0] ram_d_out;
  logic       lcd_sclk;
  logic       lcd_mosi;
  logic       lcd_cs_n;
  logic       lcd_dc;

  modport master (
    input  start, ram_d_out,
    output busy, frame_done, ram_addr_rd, ram_rd,
           lcd_sclk, lcd_mosi, lcd_cs_n, lcd_dc
  );

  modport slave (
    output start, ram_d_out,
    input  busy, frame_done, ram_addr_rd, ram_rd,
           lcd_sclk, lcd_mosi, lcd_cs_n, lcd_dc
  );
endinterface

// File: rtl/lcd_refresh_spi.sv
// Frame-buffer to 128x64 LCD refresh engine: per page sends 3 address commands then 128 data bytes over SPI mode 0.
// Define LCD_REFRESH_CONT_EN to refresh continuously after the first start instead of one frame per start.
module lcd_refresh_spi #(
  parameter int CLK_DIV = 4
) (
  input  logic               clk,
  input  logic               rst,
  lcd_refresh_spi_if.master  bus
);

  localparam int DW = $clog2(CLK_DIV) + 1;
  localparam logic [DW-1:0] HALF_LAST = DW'(CLK_DIV - 1);
`ifdef LCD_REFRESH_CONT_EN
  localparam logic [DW-1:0] GAP_LAST  = DW'(2 * CLK_DIV - 1);
`endif

  typedef enum logic [2:0] {
    IDLE, CMD_LOAD, RD_REQ, RD_WAIT, SHIFT, NEXT, DONE
  } state_e;

  state_e      state_q;
  logic [2:0]  page_q;
  logic [6:0]  col_q;
  logic [1:0]  cmdIdx_q;
  logic [2:0]  bitCnt_q;
  logic [DW-1:0] divCnt_q;
  logic [7:0]  shift_q;
  logic        busy_q;
  logic        frameDone_q;
  logic        ramRd_q;
  logic [9:0]  ramAddr_q;
  logic        sclk_q;
  logic        mosi_q;
  logic        csN_q;
  logic        dc_q;
  logic [7:0]  cmdByte;

  // Page address, then column low nibble 0, then column high nibble 0
  always_comb begin
    cmdByte = 8'h10;
    case (cmdIdx_q)
      2'd0:    cmdByte = {5'b10110, page_q};
      2'd1:    cmdByte = 8'h00;
      default: cmdByte = 8'h10;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      page_q      <= '0;
      col_q       <= '0;
      cmdIdx_q    <= '0;
      bitCnt_q    <= '0;
      divCnt_q    <= '0;
      shift_q     <= '0;
      busy_q      <= 1'b0;
      frameDone_q <= 1'b0;
      ramRd_q     <= 1'b0;
      ramAddr_q   <= '0;
      sclk_q      <= 1'b0;
      mosi_q      <= 1'b0;
      csN_q       <= 1'b1;
      dc_q        <= 1'b0;
    end else begin
      ramRd_q     <= 1'b0;
      frameDone_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            busy_q   <= 1'b1;
            csN_q    <= 1'b0;
            cmdIdx_q <= '0;
            state_q  <= CMD_LOAD;
          end
        end
        CMD_LOAD: begin
          shift_q  <= cmdByte;
          mosi_q   <= cmdByte[7];
          dc_q     <= 1'b0;
          bitCnt_q <= '0;
          divCnt_q <= '0;
          state_q  <= SHIFT;
        end
        RD_REQ: begin
          ramAddr_q <= {page_q, col_q};
          ramRd_q   <= 1'b1;
          state_q   <= RD_WAIT;
        end
        RD_WAIT: begin
          shift_q  <= bus.ram_d_out;
          mosi_q   <= bus.ram_d_out[7];
          dc_q     <= 1'b1;
          bitCnt_q <= '0;
          divCnt_q <= '0;
          state_q  <= SHIFT;
        end
        SHIFT: begin
          // MOSI only advances on the falling SCLK edge so it is stable at every rise
          if (divCnt_q == HALF_LAST) begin
            divCnt_q <= '0;
            sclk_q   <= ~sclk_q;
            if (sclk_q) begin
              if (bitCnt_q == 3'd7) begin
                state_q <= NEXT;
              end else begin
                bitCnt_q <= bitCnt_q + 3'd1;
                shift_q  <= {shift_q[6:0], 1'b0};
                mosi_q   <= shift_q[6];
              end
            end
          end else begin
            divCnt_q <= divCnt_q + DW'(1);
          end
        end
        NEXT: begin
          if (!dc_q) begin
            if (cmdIdx_q == 2'd2) begin
              state_q <= RD_REQ;
            end else begin
              cmdIdx_q <= cmdIdx_q + 2'd1;
              state_q  <= CMD_LOAD;
            end
          end else if (col_q != 7'd127) begin
            col_q   <= col_q + 7'd1;
            state_q <= RD_REQ;
          end else if (page_q != 3'd7) begin
            col_q    <= '0;
            page_q   <= page_q + 3'd1;
            cmdIdx_q <= '0;
            state_q  <= CMD_LOAD;
          end else begin
            frameDone_q <= 1'b1;
            csN_q       <= 1'b1;
            page_q      <= '0;
            col_q       <= '0;
            divCnt_q    <= '0;
`ifndef LCD_REFRESH_CONT_EN
            busy_q      <= 1'b0;
`endif
            state_q     <= DONE;
          end
        end
        DONE: begin
`ifdef LCD_REFRESH_CONT_EN
          // Chip select stays high for two SCLK half-periods between frames
          if (divCnt_q == GAP_LAST) begin
            divCnt_q <= '0;
            csN_q    <= 1'b0;
            cmdIdx_q <= '0;
            state_q  <= CMD_LOAD;
          end else begin
            divCnt_q <= divCnt_q + DW'(1);
          end
`else
          state_q <= IDLE;
`endif
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy        = busy_q;
  assign bus.frame_done  = frameDone_q;
  assign bus.ram_addr_rd = ramAddr_q;
  assign bus.ram_rd      = ramRd_q;
  assign bus.lcd_sclk    = sclk_q;
  assign bus.lcd_mosi    = mosi_q;
  assign bus.lcd_cs_n    = csN_q;
  assign bus.lcd_dc      = dc_q;

endmodule

// File: doc/lcd_refresh_spi.md
# lcd_refresh_spi

Display refresh engine that sits directly downstream of the screen frame-buffer RAM. It walks the 8 pages × 128 columns of the buffer through the RAM read port (`addr_rd`/`rd`/`d_out`) and streams each byte to the 128×64 LCD controller over a 4-wire SPI link (SCLK, MOSI, CS_N, D/C). Before each page's data it issues the page/column addressing commands.

## Interface
- `CLK_DIV`, default 4: SCLK half-period in `clk` cycles; legal range ≥1.
- `clk`  in  1  system clock; all logic on posedge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle pulse that begins a frame; ignored while `busy`=1.
- `busy`  out  1  high from the cycle after an accepted `start` until the frame ends.
- `frame_done`  out  1  one-cycle pulse after the last data bit of page 7.
- `ram_addr_rd`  out  10  buffer read address, {page[2:0], col[6:0]}.
- `ram_rd`  out  1  buffer read strobe, one cycle per byte.
- `ram_d_out`  in  8  buffer read data; valid on the posedge after the `ram_rd` cycle (RAM registers on negedge).
- `lcd_sclk`  out  1  SPI clock, mode 0, idle low.
- `lcd_mosi`  out  1  SPI data, MSB first.
- `lcd_cs_n`  out  1  chip select, active low.
- `lcd_dc`  out  1  0 = command byte, 1 = display data byte.

## Operation
- Reset values: `busy`=0, `frame_done`=0, `ram_rd`=0, `ram_addr_rd`=0, `lcd_sclk`=0, `lcd_mosi`=0, `lcd_cs_n`=1, `lcd_dc`=0; FSM in IDLE, page=0, col=0.
- FSM states: IDLE, CMD_LOAD, RD_REQ, RD_WAIT, SHIFT, NEXT, DONE.
- IDLE → CMD_LOAD on `start`. `lcd_cs_n` goes low at the same time and stays low for the whole frame.
- CMD_LOAD: loads the per-page command byte into the shift register with `lcd_dc`=0. The sequence is 0xB0|page, then 0x00, then 0x10. Each byte goes to SHIFT.
- After the third command byte, NEXT → RD_REQ.
- RD_REQ: `ram_addr_rd`={page,col}, `ram_rd`=1 for exactly one cycle. Then go to RD_WAIT.
- RD_WAIT: latch `ram_d_out` into the shift register, set `lcd_dc`=1, then go to SHIFT.
- SHIFT: sends 8 bits MSB first.
  - `lcd_mosi` changes only while `lcd_sclk` is low.
  - Each bit is `CLK_DIV` cycles low followed by `CLK_DIV` cycles high.
  - The byte ends with SCLK returned low.
- NEXT:
  - col<127: col+1 → RD_REQ.
  - col=127 and page<7: col=0, page+1 → CMD_LOAD.
  - col=127 and page=7 → DONE.
- DONE: `frame_done`=1 for one cycle, `lcd_cs_n`=1, `busy`=0, page/col cleared, → IDLE.
- Counters: col is 7 bits and page is 3 bits; neither wraps mid-frame. Bit counter 3 bits; divider counter `$clog2(CLK_DIV)+1` bits.
- A frame is 8×(3+128)=1048 bytes.
- `rst` in any state returns all outputs to reset values on the next edge. A partial SPI byte is abandoned.

## Timing
- `start` accepted at edge N: `busy`=1 and `lcd_cs_n`=0 from edge N+1. CMD_LOAD occupies cycle N+1; first SCLK rise at N+2+`CLK_DIV`.
- Per byte: 16·`CLK_DIV` SHIFT cycles plus 1 NEXT cycle. Command bytes add 1 CMD_LOAD cycle; data bytes add RD_REQ + RD_WAIT (2 cycles).
- Frame length with `CLK_DIV`=1: 24×18 + 1024×19 + 1 (DONE) = 19889 cycles from first CMD_LOAD to `frame_done`.
- `start` coincident with `frame_done` is ignored.

## Configuration
- `LCD_REFRESH_CONT_EN` undefined: one frame per `start` pulse, as above.
- `LCD_REFRESH_CONT_EN` defined: after the first accepted `start`, DONE goes to CMD_LOAD (page 0) instead of IDLE.
  - `frame_done` still pulses each frame.
  - `lcd_cs_n` is high for exactly 2·`CLK_DIV` cycles between frames.
  - `busy` stays 1 until `rst`.
  - Further `start` pulses are ignored.

## Test plan
- `rst` held 3 cycles mid-SHIFT → next edge: `lcd_cs_n`=1, `lcd_sclk`=0, `ram_rd`=0, `busy`=0.
- `CLK_DIV`=1, `start` → first three SPI bytes decoded = 0xB0, 0x00, 0x10 with `lcd_dc`=0; fourth byte has `lcd_dc`=1 and `ram_addr_rd`=0x000.
- RAM model returning byte = col ^ page → MOSI decode matches for all 1024 data bytes. `ram_addr_rd` runs 0x000…0x07F on page 0; page 3 starts at 0x180 preceded by command 0xB3.
- `CLK_DIV`=3 → SCLK high and low phases each 3 cycles; MOSI stable across every rising edge; `frame_done` pulses once, 1 cycle wide.
- `start` re-pulsed mid-frame → ignored: byte count stays 1048 and the address sequence is unbroken.
- With `LCD_REFRESH_CONT_EN`: two consecutive frames; `lcd_cs_n` high for 2·`CLK_DIV` cycles between them; second frame starts with command 0xB0.
